// File: rtl/compute_kernel_pkg.sv
// Shared definitions for the blur convolution kernel: widths, default size, FSM states.
package compute_kernel_pkg;

    localparam int MAX_KERNEL_DEF = 7;
    localparam int PROD_W         = 16;
    localparam int ACC_W          = 22;
    localparam int WSUM_W         = 14;
    localparam int QUOT_W         = 8;
    localparam int DIV_CNT_W      = $clog2(QUOT_W);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/compute_kernel_divider.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle, MSB first.
// The dividend must be smaller than divisor * 2^QUOT_W so the quotient fits.
module kernel_divider
    import compute_kernel_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ACC_W-1:0]  dividend,
    input  logic [WSUM_W-1:0] divisor,
    output logic              busy,
    output logic [QUOT_W-1:0] quotient
);

    logic [ACC_W-1:0]     rem_q, rem_d;
    logic [ACC_W-1:0]     shift_q, shift_d;
    logic [QUOT_W-1:0]    quot_q, quot_d;
    logic [DIV_CNT_W-1:0] count_q, count_d;
    logic                 busy_q, busy_d;

    // Load operands on start, otherwise try subtracting the shifted divisor once per cycle.
    always_comb begin
        rem_d   = rem_q;
        shift_d = shift_q;
        quot_d  = quot_q;
        count_d = count_q;
        busy_d  = busy_q;
        if (start) begin
            rem_d   = dividend;
            shift_d = ACC_W'({divisor, {(QUOT_W-1){1'b0}}});
            quot_d  = '0;
            count_d = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (rem_q >= shift_q) begin
                rem_d  = rem_q - shift_q;
                quot_d = {quot_q[QUOT_W-2:0], 1'b1};
            end else begin
                quot_d = {quot_q[QUOT_W-2:0], 1'b0};
            end
            shift_d = shift_q >> 1;
            count_d = count_q + DIV_CNT_W'(1);
            if (count_q == DIV_CNT_W'(QUOT_W-1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rem_q   <= '0;
            shift_q <= '0;
            quot_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            shift_q <= shift_d;
            quot_q  <= quot_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign quotient = quot_q;

endmodule

// File: rtl/compute_kernel.sv
// Weighted k x k convolution of a pixel window, normalized by the weight sum with rounding.
// One multiply-accumulate per cycle, then a serial division of the rounded sum.
module compute_kernel
    import compute_kernel_pkg::*;
#(
    parameter int MAX_KERNEL = MAX_KERNEL_DEF
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic [$clog2(MAX_KERNEL)-1:0]         kernel_size,
    input  logic                                  start,
    input  logic                                  clear,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] input_matrix,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] kernel,
    output logic                                  done,
    output logic [QUOT_W-1:0]                     blurred_pixel,
    output logic                                  clear_flag
);

    localparam int IDX_W = $clog2(MAX_KERNEL);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  k_last_q, k_last_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WSUM_W-1:0] wsum_q, wsum_d;
    logic              done_q, done_d;
    logic [QUOT_W-1:0] blurred_q, blurred_d;
    logic              clear_flag_q, clear_flag_d;

    logic [7:0]        pixel;
    logic [7:0]        weight;
    logic [PROD_W-1:0] product;
    logic              div_start;
    logic [ACC_W-1:0]  div_dividend;
    logic [WSUM_W-1:0] div_divisor;
    logic              div_busy;
    logic [QUOT_W-1:0] div_quotient;

    // Next-state logic: clear overrides everything; the divider is loaded with the final rounded sum on the last MAC cycle.
    always_comb begin
        state_d      = state_q;
        k_last_d     = k_last_q;
        i_d          = i_q;
        j_d          = j_q;
        acc_d        = acc_q;
        wsum_d       = wsum_q;
        done_d       = 1'b0;
        blurred_d    = blurred_q;
        clear_flag_d = clear_flag_q;
        div_start    = 1'b0;

        pixel   = input_matrix[i_q][j_q];
        weight  = kernel[i_q][j_q];
        product = PROD_W'(pixel) * PROD_W'(weight);

        if (clear) begin
            state_d   = IDLE;
            blurred_d = '0;
            if (state_q == MAC || state_q == DIV) begin
                clear_flag_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (kernel_size == '0) begin
                            k_last_d = '0;
                        end else if (int'(kernel_size) > MAX_KERNEL) begin
                            k_last_d = IDX_W'(MAX_KERNEL - 1);
                        end else begin
                            k_last_d = kernel_size - IDX_W'(1);
                        end
                        i_d          = '0;
                        j_d          = '0;
                        acc_d        = '0;
                        wsum_d       = '0;
                        clear_flag_d = 1'b0;
                        state_d      = MAC;
                    end
                end
                MAC: begin
                    acc_d  = acc_q + ACC_W'(product);
                    wsum_d = wsum_q + WSUM_W'(weight);
                    if (j_q == k_last_q) begin
                        j_d = '0;
                        i_d = i_q + IDX_W'(1);
                        if (i_q == k_last_q) begin
                            div_start = 1'b1;
                            state_d   = DIV;
                        end
                    end else begin
                        j_d = j_q + IDX_W'(1);
                    end
                end
                DIV: begin
                    if (!div_busy) begin
                        blurred_d = (wsum_q == '0) ? '0 : div_quotient;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        div_dividend = acc_d + ACC_W'(wsum_d >> 1);
        div_divisor  = wsum_d;
    end

    // FSM, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            k_last_q     <= '0;
            i_q          <= '0;
            j_q          <= '0;
            acc_q        <= '0;
            wsum_q       <= '0;
            done_q       <= 1'b0;
            blurred_q    <= '0;
            clear_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_last_q     <= k_last_d;
            i_q          <= i_d;
            j_q          <= j_d;
            acc_q        <= acc_d;
            wsum_q       <= wsum_d;
            done_q       <= done_d;
            blurred_q    <= blurred_d;
            clear_flag_q <= clear_flag_d;
        end
    end

    kernel_divider u_divider (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .quotient (div_quotient)
    );

    assign done          = done_q;
    assign blurred_pixel = blurred_q;
    assign clear_flag    = clear_flag_q;

endmodule

// File: tb/tb_compute_kernel.sv
// Scoreboard bench for compute_kernel: expected pixel and latency are queued at start
// and compared when done is observed.
module tb_compute_kernel;

    localparam int MK   = 7;
    localparam int KS_W = $clog2(MK);

    typedef struct {
        int pixel;
        int latency;
    } expect_t;

    logic                       clk = 1'b0;
    logic                       n_rst = 1'b0;
    logic                       start = 1'b0;
    logic                       clear = 1'b0;
    logic [KS_W-1:0]            kernel_size = '0;
    logic [MK-1:0][MK-1:0][7:0] input_matrix = '0;
    logic [MK-1:0][MK-1:0][7:0] kernel = '0;
    logic                       done;
    logic [7:0]                 blurred_pixel;
    logic                       clear_flag;

    expect_t scoreboard[$];
    int      compareCount = 0;
    int      mismatchCount = 0;

    compute_kernel #(.MAX_KERNEL(MK)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .kernel_size   (kernel_size),
        .start         (start),
        .clear         (clear),
        .input_matrix  (input_matrix),
        .kernel        (kernel),
        .done          (done),
        .blurred_pixel (blurred_pixel),
        .clear_flag    (clear_flag)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference result computed from the bench's own copy of the window and weights.
    function automatic int modelPixel(input int k);
        int acc;
        int wsum;
        acc = 0;
        wsum = 0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                acc  += int'(input_matrix[i][j]) * int'(kernel[i][j]);
                wsum += int'(kernel[i][j]);
            end
        end
        if (wsum == 0) return 0;
        return (acc + wsum / 2) / wsum;
    endfunction

    task automatic fillRandom();
        for (int i = 0; i < MK; i++) begin
            for (int j = 0; j < MK; j++) begin
                input_matrix[i][j] = 8'($urandom_range(0, 255));
                kernel[i][j]       = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // Pulse start for one cycle; returns at the falling edge after start was sampled.
    task automatic startOnly(input int kField);
        @(negedge clk);
        kernel_size = KS_W'(kField);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Queue the expectation, launch the operation, and confirm the flag cleared on acceptance.
    task automatic applyStimulus(input int kField, input int expPixel);
        expect_t e;
        int      kEff;
        kEff = (kField == 0) ? 1 : kField;
        e.pixel = expPixel;
        e.latency = kEff * kEff + 9;
        scoreboard.push_back(e);
        startOnly(kField);
        checkOutput("clear_flag_after_start", int'(clear_flag), 0);
    endtask

    // Wait (bounded) for done, then pop and compare; optionally re-pulse start mid-run.
    task automatic waitForDone(input int restartAt);
        int      cycles;
        bit      seen;
        expect_t e;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = (cycles == restartAt);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        checkOutput("done_seen", int'(seen), 1);
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            if (seen) begin
                checkOutput("blurred_pixel", int'(blurred_pixel), e.pixel);
                checkOutput("latency", cycles, e.latency);
                @(negedge clk);
                checkOutput("done_width", int'(done), 0);
                checkOutput("pixel_hold", int'(blurred_pixel), e.pixel);
            end
        end
    endtask

    task automatic expectNoDone(input string tag, input int n);
        int count;
        count = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (done) count++;
        end
        checkOutput(tag, count, 0);
    endtask

    initial begin
        int rows[3][3];
        int gauss[3][3];
        int k;
        rows  = '{'{10, 10, 10}, '{10, 50, 50}, '{10, 50, 200}};
        gauss = '{'{94, 155, 94}, '{155, 255, 155}, '{94, 155, 94}};

        // Reset
        fillRandom();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_pixel", int'(blurred_pixel), 0);
        checkOutput("reset_clear_flag", int'(clear_flag), 0);
        n_rst = 1'b1;

        // k=3, unit weights, known window; out-of-window entries stay random
        fillRandom();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                input_matrix[i][j] = 8'(rows[i][j]);
                kernel[i][j] = 8'd1;
            end
        end
        applyStimulus(3, 44);
        waitForDone(-1);

        // clear while idle zeroes the result but does not flag an abort
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("idle_clear_pixel", int'(blurred_pixel), 0);
        checkOutput("idle_clear_flag", int'(clear_flag), 0);

        // Gaussian weights over a flat window
        fillRandom();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                input_matrix[i][j] = 8'd10;
                kernel[i][j] = 8'(gauss[i][j]);
            end
        end
        applyStimulus(3, 10);
        waitForDone(-1);

        // k=1 single element
        fillRandom();
        kernel[0][0] = 8'd5;
        input_matrix[0][0] = 8'd200;
        applyStimulus(1, 200);
        waitForDone(-1);

        // kernel_size 0 behaves as k=1
        fillRandom();
        kernel[0][0] = 8'd3;
        input_matrix[0][0] = 8'd77;
        applyStimulus(0, 77);
        waitForDone(-1);

        // all-zero weights give zero
        fillRandom();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                kernel[i][j] = 8'd0;
            end
        end
        applyStimulus(3, 0);
        waitForDone(-1);

        // largest kernel
        fillRandom();
        applyStimulus(7, modelPixel(7));
        waitForDone(-1);

        // start re-pulsed during division is ignored
        fillRandom();
        applyStimulus(3, modelPixel(3));
        waitForDone(12);
        expectNoDone("restart_extra_done", 30);

        // clear in the third MAC cycle aborts
        fillRandom();
        startOnly(3);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("abort_clear_flag", int'(clear_flag), 1);
        checkOutput("abort_pixel", int'(blurred_pixel), 0);
        expectNoDone("abort_done", 30);

        // clear and start together: start dropped, flag untouched
        @(negedge clk);
        kernel_size = KS_W'(3);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        expectNoDone("clear_start_done", 20);
        checkOutput("clear_start_flag", int'(clear_flag), 1);

        // recovery after abort
        fillRandom();
        applyStimulus(3, modelPixel(3));
        waitForDone(-1);

        // reset mid-operation
        startOnly(3);
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        checkOutput("midreset_pixel", int'(blurred_pixel), 0);
        checkOutput("midreset_clear_flag", int'(clear_flag), 0);
        expectNoDone("midreset_done", 30);

        // random sizes and contents
        for (int t = 0; t < 6; t++) begin
            fillRandom();
            k = int'($urandom_range(1, MK));
            applyStimulus(k, modelPixel(k));
            waitForDone(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/compute_kernel.md
COMPUTE_KERNEL -- requirements
Module: compute_kernel

Interface
REQ-001 Parameter MAX_KERNEL, default 7, maximum kernel edge length in elements.
REQ-002 Clocking is fixed: one clock; reset is synchronous and active-low, ports named clk and n_rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 n_rst  input  1  synchronous active-low reset.
REQ-005 kernel_size  input  $clog2(MAX_KERNEL)  active kernel edge length k, valid 1..MAX_KERNEL; 0 treated as 1.
REQ-006 start  input  1  single-cycle request to begin one convolution.
REQ-007 done  output  1  one-cycle pulse; blurred_pixel is valid from this cycle on.
REQ-008 input_matrix  input  MAX_KERNEL x MAX_KERNEL x 8  unsigned pixel window, indexed [row][col].
REQ-009 kernel  input  MAX_KERNEL x MAX_KERNEL x 8  unsigned weights, indexed [row][col]; normally driven by CreateKernel (Gaussian weights).
REQ-010 blurred_pixel  output  8  normalized convolution result.
REQ-011 clear  input  1  synchronous abort request.
REQ-012 clear_flag  output  1  sticky status: last operation was aborted by clear.

Function
REQ-013 Result: round(sum(input_matrix[i][j]*kernel[i][j]) / sum(kernel[i][j])) over 0<=i,j<k; rounding computes floor((acc + wsum/2) / wsum).
REQ-014 If wsum = 0, blurred_pixel = 0.
REQ-015 Widths: each product 16 bits; acc 22 bits; wsum 14 bits; quotient fits 8 bits by construction, no saturation needed.
REQ-016 FSM states: IDLE, MAC, DIV, DONE.
REQ-017 IDLE: start=1 latches k, clears acc/wsum/indices, goes to MAC; all other inputs are ignored.
REQ-018 MAC: one element per cycle, row-major (i outer, j inner); after k*k elements go to DIV.
REQ-019 DIV: 8-iteration restoring division, one quotient bit per cycle, MSB first; then go to DONE.
REQ-020 DONE: register the quotient into blurred_pixel, assert done for exactly one cycle, return to IDLE.
REQ-021 Latency: done is high in the cycle beginning k*k+9 rising edges after the edge that sampled start (k=3: 18).
REQ-022 blurred_pixel holds its value until the next DONE, reset, or clear.
REQ-023 input_matrix and kernel are not latched; the source holds them stable from start to done.
REQ-024 start while not IDLE is ignored.
REQ-025 clear in any state: next state IDLE, blurred_pixel <= 0, no done.
REQ-026 clear_flag <= 1 if clear is sampled while in MAC or DIV; clear_flag <= 0 on an accepted start.
REQ-027 clear and start in the same cycle: clear wins and start is dropped.

Reset
REQ-028 While n_rst=0 at a rising edge: state IDLE, done=0, blurred_pixel=0, clear_flag=0, acc/wsum/indices/divider cleared.
REQ-029 Reset mid-operation aborts without done; clear_flag stays 0.

Structure
REQ-030 A shared package holds the MAX_KERNEL default, the FSM state enum, and the accumulator, weight-sum and quotient width constants.
REQ-031 The restoring divider is one sub-module, kernel_divider, with dividend, divisor, start, busy and quotient ports.
REQ-032 Total RTL is 120-400 lines; no combinational k*k-wide adder tree, one multiplier only.

Verification
REQ-033 Reset: n_rst=0 for one edge -> done=0, blurred_pixel=0, clear_flag=0.
REQ-034 k=3, all kernel weights 1, rows {10,10,10},{10,50,50},{10,50,200} -> blurred_pixel=44, done exactly 18 cycles after start.
REQ-035 k=3 with a CreateKernel sigma=1 kernel, input all 10 -> blurred_pixel=10.
REQ-036 k=1, kernel[0][0]=5, input[0][0]=200 -> blurred_pixel=200, done after 10 cycles; all-zero kernel -> 0.
REQ-037 clear pulsed in the 3rd MAC cycle -> no done, clear_flag=1, blurred_pixel=0; next start -> clear_flag=0 and a correct result.
REQ-038 start re-pulsed during DIV -> ignored, a single done at the original latency.
